// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the serial binary-to-BCD converter.
package bin2bcd_pkg;

  // Width of one packed BCD digit.
  localparam int BCD_DIGIT_W = 4;

  // Converter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: add 3 to a digit of 5 or more so the
// following left shift carries into the next decade.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  // Add-3 correction applied ahead of every shift.
  always_comb begin
    dout = (din >= 4'd5) ? din + 4'd3 : din;
  end

endmodule

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble binary-to-BCD converter: one bit per clock, optional
// two's complement input, sticky overflow saturating the result to all nines.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE, out_valid only in DONE; the result
// fields stay frozen while out_valid is high and out_ready is low.
module bin2bcd_serial
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BIN_W-1:0]              in_bin,
  input  logic                          in_signed,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
  output logic                          out_neg,
  output logic                          out_ovf,
  output state_t                        dbg_state
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int ACC_W = BCD_DIGIT_W * DIGITS;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   adj;
  logic [ACC_W-1:0]   acc_nxt;
  logic [ACC_W-1:0]   nines;
  logic [BIN_W-1:0]   mag;
  logic [BIN_W-1:0]   in_mag;
  logic               in_neg;
  logic               neg;
  logic               ovf;
  logic               ovf_nxt;

  // Per-digit add-3 correction and the saturation pattern.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_adj u_adj (
      .din  (acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
    assign nines[g*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'h9;
  end

  // Negating the signed minimum wraps to itself, which read unsigned is
  // exactly 2^(BIN_W-1), the magnitude wanted.
  assign in_neg  = in_signed & in_bin[BIN_W-1];
  assign in_mag  = in_neg ? -in_bin : in_bin;

  // {accumulator, magnitude} shifted left by one after correction; the bit
  // falling out of the top digit is lost precision, so it latches overflow.
  assign acc_nxt = {adj[ACC_W-2:0], mag[BIN_W-1]};
  assign ovf_nxt = ovf | adj[ACC_W-1];

  assign dbg_state = state;

  // Control FSM with datapath and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      mag       <= '0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_bcd   <= '0;
      out_neg   <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mag      <= in_mag;
            neg      <= in_neg;
            acc      <= '0;
            ovf      <= 1'b0;
            cnt      <= CNT_W'(BIN_W);
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= acc_nxt;
          mag <= {mag[BIN_W-2:0], 1'b0};
          ovf <= ovf_nxt;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_bcd   <= ovf_nxt ? nines : acc_nxt;
            out_ovf   <= ovf_nxt;
            out_neg   <= neg & (ovf_nxt | (acc_nxt != '0));
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Directed bench for bin2bcd_serial: default (14-bit, 4-digit) instance with a
// decimal reference model and per-cycle output compare, plus a 20-bit,
// 7-digit instance checked with literals and the same model.
module tb_bin2bcd_serial;
  import bin2bcd_pkg::*;

  localparam int W  = 14;
  localparam int D  = 4;
  localparam int WB = 20;
  localparam int DB = 7;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT A (defaults) ----------------
  logic           in_valid, in_ready, in_signed, out_valid, out_ready, out_neg, out_ovf;
  logic [W-1:0]   in_bin;
  logic [4*D-1:0] out_bcd;
  state_t         dbg_state;

  bin2bcd_serial #(.BIN_W(W), .DIGITS(D)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_neg   (out_neg),
    .out_ovf   (out_ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- DUT B (20-bit, 7 digits) ----------------
  logic            in_valid_b, in_ready_b, in_signed_b, out_valid_b, out_ready_b, out_neg_b, out_ovf_b;
  logic [WB-1:0]   in_bin_b;
  logic [4*DB-1:0] out_bcd_b;
  state_t          dbg_state_b;

  bin2bcd_serial #(.BIN_W(WB), .DIGITS(DB)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .in_bin    (in_bin_b),
    .in_signed (in_signed_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready_b),
    .out_bcd   (out_bcd_b),
    .out_neg   (out_neg_b),
    .out_ovf   (out_ovf_b),
    .dbg_state (dbg_state_b)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [15:0] bcd;
    logic        neg;
    logic        ovf;
    logic [15:0] lit_bcd;
    logic        lit_neg;
    logic        lit_ovf;
    logic        has_lit;
    logic [31:0] acc_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          rd_idx;
  int          n_pass;
  int          n_total;
  int unsigned cyc;
  bit          shown;
  bit          after_hs;
  int unsigned last_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Decimal reference: magnitude from the signed/unsigned reading, then
  // repeated division by ten, saturating to all nines past 10^dg-1.
  function automatic void model(input longint unsigned v, input bit s, input int w, input int dg,
                                output logic [31:0] bcd, output logic neg, output logic ovf);
    longint unsigned mag;
    longint unsigned lim;
    bit msb;
    msb = v[w-1];
    mag = (s && msb) ? ((64'd1 << w) - v) : v;
    lim = 1;
    for (int i = 0; i < dg; i++) lim = lim * 10;
    lim = lim - 1;
    ovf = (mag > lim);
    neg = s && msb && (mag != 0);
    bcd = '0;
    for (int i = 0; i < dg; i++) begin
      if (ovf) bcd[4*i +: 4] = 4'h9;
      else begin
        bcd[4*i +: 4] = 4'(mag % 10);
        mag = mag / 10;
      end
    end
  endfunction

  task automatic cycle_counter();
    forever begin
      @(posedge clk);
      cyc++;
    end
  endtask

  // Checks DUT A on every cycle its result is presented.
  task automatic compare_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_idx   = exp_q.size();
        shown    = 0;
        after_hs = 0;
      end else if (out_valid) begin
        if (rd_idx >= exp_q.size()) begin
          chk("spurious_out_valid", out_valid, 1'b0);
        end else begin
          e = exp_q[rd_idx];
          if (!shown) begin
            chk("latency", cyc - e.acc_cyc, W);
            if (e.has_lit) begin
              chk("lit_bcd", out_bcd, e.lit_bcd);
              chk("lit_neg", out_neg, e.lit_neg);
              chk("lit_ovf", out_ovf, e.lit_ovf);
            end
            shown = 1;
          end
          chk("model_bcd", out_bcd, e.bcd);
          chk("model_neg", out_neg, e.neg);
          chk("model_ovf", out_ovf, e.ovf);
          chk("in_ready_in_done", in_ready, 1'b0);
          if (out_ready) begin
            rd_idx++;
            shown    = 0;
            after_hs = 1;
          end
        end
      end else if (after_hs) begin
        chk("idle_after_result", in_ready, 1'b1);
        after_hs = 0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] v, input bit s, input bit has_lit,
                      input logic [15:0] lb, input bit ln, input bit lo, input bit b2b);
    exp_t        e;
    logic [31:0] mb;
    logic        mn, mo;
    int          guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", in_ready, 1'b1);
      return;
    end
    in_valid  = 1'b1;
    in_bin    = v;
    in_signed = s;
    model(v, s, W, D, mb, mn, mo);
    e.bcd     = mb[15:0];
    e.neg     = mn;
    e.ovf     = mo;
    e.lit_bcd = lb;
    e.lit_neg = ln;
    e.lit_ovf = lo;
    e.has_lit = has_lit;
    @(posedge clk); #1;
    e.acc_cyc = cyc;
    exp_q.push_back(e);
    chk("accepted", in_ready, 1'b0);
    if (b2b) chk("throughput", cyc - last_acc, W + 2);
    last_acc  = cyc;
    // Garbage on the inputs while shifting must not reach the result.
    in_valid  = 1'b0;
    in_bin    = W'($urandom);
    in_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((rd_idx < exp_q.size() || !in_ready) && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 2000) chk("drain_timeout", 1'b0, 1'b1);
  endtask

  task automatic run_b(input logic [WB-1:0] v, input bit s, input bit has_lit,
                       input logic [27:0] lb, input bit ln, input bit lo);
    logic [31:0] mb;
    logic        mn, mo;
    int          n;
    model(v, s, WB, DB, mb, mn, mo);
    chk("b_ready", in_ready_b, 1'b1);
    in_valid_b  = 1'b1;
    in_bin_b    = v;
    in_signed_b = s;
    @(posedge clk); #1;
    in_valid_b  = 1'b0;
    in_bin_b    = WB'($urandom);
    n = 0;
    while (!out_valid_b && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b_latency", n, WB);
    chk("b_model_bcd", out_bcd_b, mb[27:0]);
    chk("b_model_neg", out_neg_b, mn);
    chk("b_model_ovf", out_ovf_b, mo);
    if (has_lit) begin
      chk("b_lit_bcd", out_bcd_b, lb);
      chk("b_lit_neg", out_neg_b, ln);
      chk("b_lit_ovf", out_ovf_b, lo);
    end
    @(posedge clk); #1;
    chk("b_idle_after", in_ready_b, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_bin = '0; in_signed = 1'b0; out_ready = 1'b1;
    in_valid_b = 1'b0; in_bin_b = '0; in_signed_b = 1'b0; out_ready_b = 1'b1;
    rd_idx = 0; n_pass = 0; n_total = 0; cyc = 0; shown = 0; after_hs = 0; last_acc = 0;
    fork
      cycle_counter();
      compare_loop();
    join_none

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_bcd", out_bcd, 16'h0000);
    chk("rst_out_neg", out_neg, 1'b0);
    chk("rst_out_ovf", out_ovf, 1'b0);
    chk("rst_state", dbg_state, IDLE);
    chk("rst_b_in_ready", in_ready_b, 1'b1);
    chk("rst_b_out_valid", out_valid_b, 1'b0);
    rst = 1'b0;

    // Directed vectors, back to back with out_ready high.
    send(14'h270F, 1'b0, 1'b1, 16'h9999, 1'b0, 1'b0, 1'b0);
    send(14'h3FFF, 1'b0, 1'b1, 16'h9999, 1'b0, 1'b1, 1'b1);
    send(14'h3FFF, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b1);
    send(14'h2000, 1'b1, 1'b1, 16'h8192, 1'b1, 1'b0, 1'b1);
    send(14'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    send(14'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    send(14'h2710, 1'b0, 1'b1, 16'h9999, 1'b0, 1'b1, 1'b1);
    send(14'h1FFF, 1'b1, 1'b1, 16'h8191, 1'b0, 1'b0, 1'b1);
    send(14'h04D2, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1);
    send(14'h3B2E, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b1);
    send(14'h2000, 1'b0, 1'b1, 16'h8192, 1'b0, 1'b0, 1'b1);
    send(14'h0005, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b1);
    wait_drain();

    // Back-pressure: result held 5 cycles, new requests ignored meanwhile.
    out_ready = 1'b0;
    send(14'h10E1, 1'b0, 1'b1, 16'h4321, 1'b0, 1'b0, 1'b0);
    for (int g = 0; g < 100 && !out_valid; g++) begin
      @(posedge clk); #1;
    end
    chk("hold_reached_done", out_valid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      in_valid  = 1'b1;
      in_bin    = W'($urandom);
      in_signed = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    chk("hold_still_done", dbg_state, DONE);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    // Reset in the 5th shift cycle aborts; the next request is clean.
    send(14'd777, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_in_shift", dbg_state, SHIFT);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_out_bcd", out_bcd, 16'h0000);
    chk("abort_out_neg", out_neg, 1'b0);
    chk("abort_out_ovf", out_ovf, 1'b0);
    rst = 1'b0;
    send(14'd1234, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    wait_drain();

    // Random operands against the model.
    for (int i = 0; i < 150; i++) begin
      send(W'($urandom_range(0, 16383)), 1'($urandom_range(0, 1)), 1'b0, 16'h0, 1'b0, 1'b0, i > 0);
    end
    wait_drain();

    // Wide instance.
    run_b(20'hFFFFF, 1'b0, 1'b1, 28'h1048575, 1'b0, 1'b0);
    run_b(20'h80000, 1'b1, 1'b1, 28'h0524288, 1'b1, 1'b0);
    run_b(20'hFFFFF, 1'b1, 1'b1, 28'h0000001, 1'b1, 1'b0);
    run_b(20'd999999, 1'b0, 1'b1, 28'h0999999, 1'b0, 1'b0);
    run_b(20'd0, 1'b1, 1'b1, 28'h0000000, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      run_b(WB'($urandom), 1'($urandom_range(0, 1)), 1'b0, 28'h0, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bin2bcd_serial.md
BIN2BCD_SERIAL -- requirements
Module: bin2bcd_serial

Interface
REQ-001 Parameter BIN_W, default 14, binary input width in bits (>=2).
REQ-002 Parameter DIGITS, default 4, number of BCD output digits (>=1).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port in_valid  input  1  source offers a conversion request.
REQ-006 Port in_ready  output  1  block can accept a request.
REQ-007 Port in_bin  input  BIN_W  binary operand.
REQ-008 Port in_signed  input  1  1 = treat in_bin as two's complement; 0 = unsigned.
REQ-009 Port out_valid  output  1  result available.
REQ-010 Port out_ready  input  1  sink accepts result.
REQ-011 Port out_bcd  output  4*DIGITS  BCD result, digit 0 (ones) in bits [3:0].
REQ-012 Port out_neg  output  1  result is negative (signed mode only).
REQ-013 Port out_ovf  output  1  magnitude exceeds 10^DIGITS-1.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 Accept occurs on a rising edge with in_valid & in_ready: load magnitude (in_signed & in_bin[BIN_W-1] ? -in_bin : in_bin, as BIN_W-bit unsigned), latch out_neg, clear BCD accumulator and overflow flag, load iteration counter with BIN_W, go to SHIFT.
REQ-016 Each SHIFT cycle SHALL perform one double-dabble iteration: every digit >=5 gets +3, then {accumulator, magnitude} shifts left by 1; counter decrements.
REQ-017 Any 1 bit shifted out of the top digit's MSB SHALL set the sticky overflow flag.
REQ-018 After the BIN_W-th iteration the FSM SHALL enter DONE; out_valid SHALL be high exactly BIN_W cycles after the accepting edge.
REQ-019 In DONE, out_bcd = overflow ? all digits 9 : accumulator; out_ovf = overflow; out_neg = latched sign, forced 0 when result is zero.
REQ-020 out_bcd, out_neg, out_ovf SHALL remain stable while out_valid & !out_ready.
REQ-021 DONE -> IDLE on out_valid & out_ready; no request is accepted in the same cycle (one idle cycle between results).
REQ-022 in_valid/in_bin/in_signed are ignored outside IDLE; changes during SHIFT do not affect the result.
REQ-023 Signed minimum (-2^(BIN_W-1)) SHALL convert to magnitude 2^(BIN_W-1) with out_neg=1.
REQ-024 Throughput: one conversion per BIN_W+2 cycles with out_ready held high.

Reset
REQ-025 rst SHALL force state IDLE, counter 0, accumulator 0, out_bcd 0, out_neg 0, out_ovf 0, out_valid 0, in_ready 1 on the next edge.
REQ-026 rst asserted during SHIFT or DONE SHALL abort the conversion; no out_valid pulse for it.
REQ-027 rst has priority over in_valid and out_ready in the same cycle.

Structure
REQ-028 Shared package bin2bcd_pkg SHALL hold the FSM state typedef and constant BCD_DIGIT_W = 4.
REQ-029 Sub-module bcd_digit_adj (combinational 4-bit add-3-if->=5) SHALL be instantiated DIGITS times via generate.
REQ-030 Counter width SHALL be $clog2(BIN_W+1); no other parameter-dependent logic outside generate loops.

Verification
REQ-031 Defaults, unsigned 9999 (14'h270F) -> out_bcd 16'h9999, out_ovf 0, out_neg 0, out_valid 14 cycles after accept.
REQ-032 Defaults, unsigned 16383 (14'h3FFF) -> out_ovf 1, out_bcd 16'h9999; signed 14'h3FFF -> out_bcd 16'h0001, out_neg 1; signed 14'h2000 -> 16'h8192, out_neg 1.
REQ-033 Unsigned 0 -> 16'h0000, out_neg 0, out_ovf 0; signed 0 -> out_neg 0.
REQ-034 out_ready low 5 cycles in DONE -> outputs held, in_ready 0, in_valid ignored; out_ready high -> IDLE next cycle.
REQ-035 rst at 5th SHIFT cycle -> next cycle in_ready 1, out_valid 0, all outputs 0; subsequent request 1234 -> 16'h1234.
REQ-036 BIN_W=20, DIGITS=7, unsigned 1048575 -> out_bcd 28'h1048575, out_ovf 0, latency 20 cycles; random 10k-vector compare against reference model for both parameter sets.
